// File: rtl/amiga_clken_gen.sv
// Multi-channel programmable clock-enable generator for the 28 MHz domain.
// Channels stay off until the synchronised lock flag has been stable for SETTLE_CYC cycles.

module amiga_clken_ch #(
   parameter int CNT_W = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             load_i,
   input  logic             run_i,
   input  logic [CNT_W-1:0] div_i,
   input  logic [CNT_W-1:0] phase_i,
   output logic             ce_o,
   output logic             ce_fall_o,
   output logic             clk_div_o
);
   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] TWO = CNT_W'(2);

   logic [CNT_W-1:0] cnt_q, cnt_d, na_q, na_d, div_eff, half;
   logic             ce_q, ce_d, cf_q, cf_d, cd_q, cd_d;

   always_comb begin
      div_eff = (div_i == '0) ? ONE : div_i;
      cnt_d   = cnt_q;
      na_d    = na_q;
      if (load_i) begin
         na_d  = div_eff;
         cnt_d = (phase_i < div_eff) ? phase_i : '0;
      end else if (run_i) begin
         // ratio changes land only at the period boundary
         if (cnt_q == na_q - ONE) begin
            cnt_d = '0;
            na_d  = div_eff;
         end else begin
            cnt_d = cnt_q + ONE;
         end
      end
      half = na_d >> 1;
      ce_d = run_i && (cnt_d == '0);
      cf_d = run_i && (na_d >= TWO) && (cnt_d == half);
      cd_d = run_i && ((na_d == ONE) || (cnt_d < half));
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
         na_q  <= ONE;
         ce_q  <= 1'b0;
         cf_q  <= 1'b0;
         cd_q  <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         na_q  <= na_d;
         ce_q  <= ce_d;
         cf_q  <= cf_d;
         cd_q  <= cd_d;
      end
   end

   assign ce_o      = ce_q;
   assign ce_fall_o = cf_q;
   assign clk_div_o = cd_q;
endmodule

module amiga_clken_gen #(
   parameter int NCH        = 4,
   parameter int CNT_W      = 8,
   parameter int SETTLE_CYC = 16
) (
   input  logic                 clk,
   input  logic                 areset,
   input  logic                 locked,
   input  logic [NCH*CNT_W-1:0] div,
   input  logic [NCH*CNT_W-1:0] phase,
   input  logic                 sync_req,
   output logic                 ready,
   output logic [NCH-1:0]       ce,
   output logic [NCH-1:0]       ce_fall,
   output logic [NCH-1:0]       clk_div
);
   localparam int SW = $clog2(SETTLE_CYC + 1);

   typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_RUN} state_t;

   state_t        state_q, state_d;
   logic [SW-1:0] settle_q, settle_d;
   logic          lock_meta_q, lock_s_q;
   logic          run_d, load;

   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         lock_meta_q <= 1'b0;
         lock_s_q    <= 1'b0;
         state_q     <= ST_IDLE;
         settle_q    <= '0;
      end else begin
         lock_meta_q <= locked;
         lock_s_q    <= lock_meta_q;
         state_q     <= state_d;
         settle_q    <= settle_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      settle_d = settle_q;
      case (state_q)
         ST_IDLE: begin
            if (lock_s_q) begin
               state_d  = ST_SETTLE;
               settle_d = '0;
            end
         end
         ST_SETTLE: begin
            if (!lock_s_q)                            state_d  = ST_IDLE;
            else if (settle_q == SW'(SETTLE_CYC - 1)) state_d  = ST_RUN;
            else                                      settle_d = settle_q + SW'(1);
         end
         ST_RUN: begin
            if (!lock_s_q) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs are registered from next-state values so they line up with ready.
   assign run_d = (state_d == ST_RUN);
   assign load  = run_d && ((state_q != ST_RUN) || sync_req);
   assign ready = (state_q == ST_RUN);

   for (genvar g = 0; g < NCH; g++) begin : gen_ch
      amiga_clken_ch #(.CNT_W(CNT_W)) u_ch (
         .clk_i     (clk),
         .rst_i     (areset),
         .load_i    (load),
         .run_i     (run_d),
         .div_i     (div[g*CNT_W +: CNT_W]),
         .phase_i   (phase[g*CNT_W +: CNT_W]),
         .ce_o      (ce[g]),
         .ce_fall_o (ce_fall[g]),
         .clk_div_o (clk_div[g])
      );
   end
endmodule

// File: tb/tb_amiga_clken_gen.sv
// Directed bench for amiga_clken_gen: lock/settle, ratios, phase/sync, live ratio change, lock loss, reset.

module tb_amiga_clken_gen;
   logic        clk = 1'b0;
   logic        areset, locked, sync_req;
   logic [31:0] div, phase;
   logic        ready;
   logic [3:0]  ce, ce_fall, clk_div;
   int          nchk = 0;
   int          nfail = 0;

   amiga_clken_gen #(.NCH(4), .CNT_W(8), .SETTLE_CYC(16)) dut (
      .clk(clk), .areset(areset), .locked(locked), .div(div), .phase(phase),
      .sync_req(sync_req), .ready(ready), .ce(ce), .ce_fall(ce_fall), .clk_div(clk_div)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_sync();
      sync_req = 1'b1;
      step();
      sync_req = 1'b0;
   endtask

   task automatic test_reset();
      areset = 1'b1; locked = 1'b0; sync_req = 1'b0;
      div = {4{8'd4}}; phase = '0;
      step(); step();
      nchk++;
      if (ready !== 1'b0 || ce !== 4'h0 || ce_fall !== 4'h0 || clk_div !== 4'h0) begin
         nfail++;
         $display("FAIL reset: ready=%b ce=%h cf=%h cd=%h, expected all 0", ready, ce, ce_fall, clk_div);
      end
      #2 areset = 1'b0;
   endtask

   // Raise locked and expect RUN exactly on the 19th edge, with every channel loading cnt=0.
   task automatic test_bringup(input string nm);
      locked = 1'b1;
      for (int k = 1; k <= 19; k++) begin
         logic       er;
         logic [3:0] ev;
         step();
         er = (k == 19);
         ev = er ? 4'hF : 4'h0;
         nchk++;
         if (ready !== er || ce !== ev || clk_div !== ev || ce_fall !== 4'h0) begin
            nfail++;
            $display("FAIL %s edge%0d: ready=%b ce=%h cd=%h cf=%h, expected ready=%b ce=%h cd=%h cf=0",
                     nm, k, ready, ce, clk_div, ce_fall, er, ev, ev);
         end
      end
   endtask

   task automatic test_div4();
      for (int j = 1; j <= 12; j++) begin
         logic [3:0] ece, ecf, ecd;
         step();
         ece = (j % 4 == 0) ? 4'hF : 4'h0;
         ecf = (j % 4 == 2) ? 4'hF : 4'h0;
         ecd = (j % 4 < 2)  ? 4'hF : 4'h0;
         nchk++;
         if (ce !== ece || ce_fall !== ecf || clk_div !== ecd) begin
            nfail++;
            $display("FAIL div4 cyc%0d: ce=%h cf=%h cd=%h, expected ce=%h cf=%h cd=%h", j, ce, ce_fall, clk_div, ece, ecf, ecd);
         end
      end
   endtask

   task automatic test_ratios();
      div = {8'd0, 8'd3, 8'd2, 8'd1}; phase = '0;
      pulse_sync();
      for (int j = 0; j < 6; j++) begin
         logic [3:0] ece, ecf, ecd;
         if (j > 0) step();
         ece = {1'b1, j % 3 == 0, j % 2 == 0, 1'b1};
         ecf = {1'b0, j % 3 == 1, j % 2 == 1, 1'b0};
         ecd = {1'b1, j % 3 == 0, j % 2 == 0, 1'b1};
         nchk++;
         if (ce !== ece || ce_fall !== ecf || clk_div !== ecd) begin
            nfail++;
            $display("FAIL ratios cyc%0d: ce=%h cf=%h cd=%h, expected ce=%h cf=%h cd=%h", j, ce, ce_fall, clk_div, ece, ecf, ecd);
         end
      end
   endtask

   task automatic test_phase_sync();
      div = {4{8'd4}}; phase = {8'd0, 8'd0, 8'd2, 8'd0};
      pulse_sync();
      for (int j = 0; j < 8; j++) begin
         logic [3:0] ece;
         if (j > 0) step();
         ece = {j % 4 == 0, j % 4 == 0, (j + 2) % 4 == 0, j % 4 == 0};
         nchk++;
         if (ce !== ece) begin
            nfail++;
            $display("FAIL phase cyc%0d: ce=%h, expected %h", j, ce, ece);
         end
      end
      phase = {4{8'd3}};
      pulse_sync();
      nchk++;
      if (ce !== 4'h0 || clk_div !== 4'h0 || ce_fall !== 4'h0) begin
         nfail++;
         $display("FAIL resync_load: ce=%h cd=%h cf=%h, expected 0 0 0", ce, clk_div, ce_fall);
      end
      step();
      nchk++;
      if (ce !== 4'hF) begin
         nfail++;
         $display("FAIL resync_align: ce=%h, expected f", ce);
      end
   endtask

   task automatic test_live_div();
      div = {4{8'd4}}; phase = '0;
      pulse_sync();
      for (int j = 1; j <= 13; j++) begin
         logic ece, ecf, ecd;
         step();
         if (j == 1) div[7:0] = 8'd8;
         ece = (j == 4) || (j == 12);
         ecf = (j == 2) || (j == 8);
         ecd = (j < 4) ? (j < 2) : (((j - 4) % 8) < 4);
         nchk++;
         if (ce[0] !== ece || ce_fall[0] !== ecf || clk_div[0] !== ecd) begin
            nfail++;
            $display("FAIL live_div cyc%0d: ce=%b cf=%b cd=%b, expected ce=%b cf=%b cd=%b",
                     j, ce[0], ce_fall[0], clk_div[0], ece, ecf, ecd);
         end
      end
      div = {4{8'd8}}; phase = {4{8'd9}};
      pulse_sync();
      nchk++;
      if (ce !== 4'hF || clk_div !== 4'hF || ce_fall !== 4'h0) begin
         nfail++;
         $display("FAIL phase_clamp: ce=%h cd=%h cf=%h, expected f f 0", ce, clk_div, ce_fall);
      end
      step();
      nchk++;
      if (ce !== 4'h0) begin
         nfail++;
         $display("FAIL phase_clamp_next: ce=%h, expected 0", ce);
      end
   endtask

   task automatic test_lock_loss();
      locked = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         step();
         nchk++;
         if (k < 3 && ready !== 1'b1) begin
            nfail++;
            $display("FAIL lock_loss edge%0d: ready=%b, expected 1", k, ready);
         end else if (k == 3 && (ready !== 1'b0 || ce !== 4'h0 || ce_fall !== 4'h0 || clk_div !== 4'h0)) begin
            nfail++;
            $display("FAIL lock_loss edge3: ready=%b ce=%h cf=%h cd=%h, expected all 0", ready, ce, ce_fall, clk_div);
         end
      end
      step(); step();
      test_bringup("relock");
   endtask

   task automatic test_areset();
      step(); step();
      #2 areset = 1'b1;
      #1;
      nchk++;
      if (ready !== 1'b0 || ce !== 4'h0 || ce_fall !== 4'h0 || clk_div !== 4'h0) begin
         nfail++;
         $display("FAIL async_reset: ready=%b ce=%h cf=%h cd=%h, expected all 0", ready, ce, ce_fall, clk_div);
      end
      #1 areset = 1'b0;
      test_bringup("after_reset");
   endtask

   initial begin
      test_reset();
      test_bringup("bringup");
      test_div4();
      test_ratios();
      test_phase_sync();
      test_live_div();
      test_lock_loss();
      test_areset();
      $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
      $finish;
   end
endmodule
